// File: rtl/tap_delay_line_pkg.sv
// Shared FIR datapath definitions: default geometry, the fill counter width
// helper and the common sample type.
package fir_pkg;

  localparam int W_DEF          = 16;
  localparam int TAPS_DEF       = 8;
  localparam int PRIME_FULL_DEF = 1;

  // Width needed to count 0..taps inclusive.
  function automatic int fill_width(input int taps);
    return $clog2(taps + 1);
  endfunction

  localparam int CW_DEF = fill_width(TAPS_DEF);

  typedef logic [W_DEF-1:0] sample_t;

endpackage

// File: rtl/tap_delay_line_tap_stage.sv
// One register of the tapped delay line: async reset, sync clear, load enable.
module tap_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // clr wins over en so a flush cannot be undone by a same-cycle load.
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/tap_delay_line.sv
// Tapped delay line feeding the MAC array: shifts one sample per accepted
// input, exposes every tap in parallel and tracks how many taps are real.
module tap_delay_line
  import fir_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int TAPS       = TAPS_DEF,
  parameter int PRIME_FULL = PRIME_FULL_DEF,
  localparam int CW        = fill_width(TAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W*TAPS-1:0] taps,
  output logic [CW-1:0]   fill,
  output logic            full
);

  localparam logic [CW-1:0] FILL_MAX = CW'(TAPS);

  logic          accept;
  logic [CW-1:0] fill_d;
  logic [CW-1:0] fill_q;
  logic          out_valid_d;
  logic          out_valid_q;
  logic [W-1:0]  tap_w [TAPS];

  // No skid buffer: a held window blocks the input combinationally.
  assign in_ready = !rst && !clr && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    fill_d = fill_q;
    if (clr) begin
      fill_d = '0;
    end else if (accept && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + CW'(1);
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (clr) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = (PRIME_FULL != 0) ? (fill_d == FILL_MAX) : 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Stage 0 takes the new sample; each later stage takes its predecessor.
  for (genvar k = 0; k < TAPS; k++) begin : g_stage
    logic [W-1:0] stage_in;
    if (k == 0) begin : g_head
      assign stage_in = in_data;
    end else begin : g_body
      assign stage_in = tap_w[k-1];
    end

    tap_stage #(
      .W (W)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (accept),
      .d   (stage_in),
      .q   (tap_w[k])
    );

    assign taps[k*W +: W] = tap_w[k];
  end

  assign fill      = fill_q;
  assign full      = (fill_q == FILL_MAX);
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tap_delay_line.sv
// Directed bench for tap_delay_line: one primed (wait-for-full) instance and
// one zero-padded instance, both with W=16, TAPS=4.
module tb_tap_delay_line;

  localparam int W    = 16;
  localparam int TAPS = 4;
  localparam int CW   = $clog2(TAPS + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              a_clr = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [W-1:0]      a_in_data = '0;
  logic              a_in_ready, a_out_valid, a_full;
  logic [W*TAPS-1:0] a_taps;
  logic [CW-1:0]     a_fill;

  logic              b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [W-1:0]      b_in_data = '0;
  logic              b_in_ready, b_out_valid, b_full;
  logic [W*TAPS-1:0] b_taps;
  logic [CW-1:0]     b_fill;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tap_delay_line #(.W(W), .TAPS(TAPS), .PRIME_FULL(1)) u_dut_a (
    .clk (clk), .rst (rst), .clr (a_clr),
    .in_valid (a_in_valid), .in_ready (a_in_ready), .in_data (a_in_data),
    .out_valid (a_out_valid), .out_ready (a_out_ready),
    .taps (a_taps), .fill (a_fill), .full (a_full)
  );

  tap_delay_line #(.W(W), .TAPS(TAPS), .PRIME_FULL(0)) u_dut_b (
    .clk (clk), .rst (rst), .clr (b_clr),
    .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data),
    .out_valid (b_out_valid), .out_ready (b_out_ready),
    .taps (b_taps), .fill (b_fill), .full (b_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one sample to instance a at the falling edge, check in_ready, then
  // let the rising edge happen and settle.
  task automatic send_a(input logic [W-1:0] data, input logic exp_ready, input string tag);
    @(negedge clk);
    a_in_valid  = 1'b1;
    a_in_data   = data;
    a_out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(a_in_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_taps", 64'(a_taps), 64'h0);
    check("rst_fill", 64'(a_fill), 64'h0);
    check("rst_valid", 64'(a_out_valid), 64'h0);
    a_in_valid = 1'b1;
    #1;
    check("rst_in_ready", 64'(a_in_ready), 64'h0);
    a_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Zero-padded start on instance b
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = 16'h00AA; b_out_ready = 1'b1;
    @(posedge clk); #1;
    check("pad_valid", 64'(b_out_valid), 64'h1);
    check("pad_taps", 64'(b_taps), 64'h0000_0000_0000_00AA);
    check("pad_fill", 64'(b_fill), 64'h1);
    check("pad_full", 64'(b_full), 64'h0);
    @(negedge clk);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("pad_consumed", 64'(b_out_valid), 64'h0);

    // Priming: window valid only once all four taps are real
    for (int i = 1; i <= 4; i++) begin
      send_a(W'(i), 1'b1, "prime");
      check("prime_fill", 64'(a_fill), 64'(i));
      check("prime_valid", 64'(a_out_valid), 64'(i == 4));
    end
    check("prime_full", 64'(a_full), 64'h1);
    check("prime_taps", 64'(a_taps), 64'h0001_0002_0003_0004);

    // Streaming with saturated fill
    send_a(16'h0005, 1'b1, "stream");
    check("stream_valid", 64'(a_out_valid), 64'h1);
    check("stream_taps", 64'(a_taps), 64'h0002_0003_0004_0005);
    check("stream_fill", 64'(a_fill), 64'h4);

    // Backpressure holds everything
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = 16'h0006; a_out_ready = 1'b0;
      #1;
      check("bp_in_ready", 64'(a_in_ready), 64'h0);
      @(posedge clk); #1;
      check("bp_taps", 64'(a_taps), 64'h0002_0003_0004_0005);
      check("bp_valid", 64'(a_out_valid), 64'h1);
    end
    send_a(16'h0006, 1'b1, "bp_release");
    check("bp_release_taps", 64'(a_taps), 64'h0003_0004_0005_0006);
    check("bp_release_valid", 64'(a_out_valid), 64'h1);

    // Flush wins over a same-cycle sample
    @(negedge clk);
    a_clr = 1'b1; a_in_valid = 1'b1; a_in_data = 16'h1234; a_out_ready = 1'b0;
    #1;
    check("clr_in_ready", 64'(a_in_ready), 64'h0);
    @(posedge clk); #1;
    check("clr_taps", 64'(a_taps), 64'h0);
    check("clr_fill", 64'(a_fill), 64'h0);
    check("clr_valid", 64'(a_out_valid), 64'h0);
    @(negedge clk);
    a_clr = 1'b0; a_in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_no_1234", 64'(a_taps), 64'h0);

    // Async reset mid-stream
    send_a(16'h0007, 1'b1, "pre_rst");
    send_a(16'h0008, 1'b1, "pre_rst");
    send_a(16'h0009, 1'b1, "pre_rst");
    check("pre_rst_fill", 64'(a_fill), 64'h3);
    #2;
    rst = 1'b1;
    a_in_data = 16'h000A;
    #1;
    check("async_taps", 64'(a_taps), 64'h0);
    check("async_fill", 64'(a_fill), 64'h0);
    check("async_valid", 64'(a_out_valid), 64'h0);
    check("async_in_ready", 64'(a_in_ready), 64'h0);
    @(negedge clk);
    a_in_valid = 1'b0;
    rst = 1'b0;
    send_a(16'h00BB, 1'b1, "post_rst");
    check("post_rst_taps", 64'(a_taps), 64'h0000_0000_0000_00BB);
    check("post_rst_fill", 64'(a_fill), 64'h1);
    check("post_rst_valid", 64'(a_out_valid), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
